// File: rtl/duck_spawn_ctrl_pkg.sv
// Shared game definitions: game-state encodings, screen/duck geometry and
// the position clamp used when a duck spawns.
package duck_spawn_ctrl_pkg;

   typedef enum logic [1:0] {
      GsStart = 2'b00,
      GsPlay  = 2'b01,
      GsEnd   = 2'b10
   } game_state_e;

   localparam int unsigned SCREEN_W  = 960;
   localparam int unsigned SCREEN_H  = 704;
   localparam int unsigned DUCK_SIZE = 64;
   localparam int unsigned HUD_H     = 96;

   // Legal top-left corners keep the whole duck sprite below the HUD and on screen.
   localparam logic [9:0] X_MAX   = 10'(SCREEN_W - DUCK_SIZE);
   localparam logic [9:0] Y_MIN   = 10'(HUD_H);
   localparam logic [9:0] Y_MAX   = 10'(SCREEN_H - DUCK_SIZE);
   localparam logic [9:0] X_RESET = 10'd450;
   localparam logic [9:0] Y_RESET = Y_MIN;

   function automatic logic [9:0] clamp_pos(input logic [9:0] v, input logic [9:0] lo,
                                            input logic [9:0] hi);
      logic [9:0] r;
      r = v;
      if (v < lo) r = lo;
      else if (v > hi) r = hi;
      return r;
   endfunction

endpackage

// File: rtl/duck_timer.sv
// Loadable down-counter that stops at zero and flags it.
module duck_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/duck_spawn_ctrl.sv
// Duck spawn sequencer: requests a position, shows the duck for a lifetime,
// scores hits/escapes, pauses between ducks and ends the round.
module duck_spawn_ctrl
   import duck_spawn_ctrl_pkg::*;
#(
   parameter int unsigned LIFETIME_CYC    = 65_000_000,
   parameter int unsigned GAP_CYC         = 32_500_000,
   parameter int unsigned DUCKS_PER_ROUND = 10,
   parameter int unsigned MAX_MISSES      = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] state,
   input  logic       clicked_duck,
   input  logic [9:0] hor_data,
   input  logic [9:0] ver_data,
   output logic       pos_req,
   output logic [9:0] duck_x,
   output logic [9:0] duck_y,
   output logic       duck_visible,
   output logic [7:0] hits,
   output logic [3:0] misses,
   output logic [3:0] spawned,
   output logic       round_over
);

   localparam int unsigned LIFE_W = $clog2(LIFETIME_CYC + 1);
   localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);
   localparam logic [LIFE_W-1:0] LIFE_LOAD = LIFE_W'(LIFETIME_CYC - 1);
   localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYC - 1);
   localparam logic [3:0] DUCKS_LIM = 4'(DUCKS_PER_ROUND);
   localparam logic [3:0] MISS_LIM  = 4'(MAX_MISSES);

   typedef enum logic [2:0] {StIdle, StReq, StLoad, StActive, StGap, StDone} fsm_e;

   fsm_e       st_q, st_d;
   logic [7:0] hits_q, hits_d;
   logic [3:0] misses_q, misses_d, spawned_q, spawned_d;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic       life_load, life_zero, gap_load, gap_zero, tmr_clear, play;

   assign play = (state == GsPlay);

   always_comb begin
      st_d         = st_q;
      hits_d       = hits_q;
      misses_d     = misses_q;
      spawned_d    = spawned_q;
      x_d          = x_q;
      y_d          = y_q;
      life_load    = 1'b0;
      gap_load     = 1'b0;
      tmr_clear    = 1'b0;
      pos_req      = 1'b0;
      duck_visible = 1'b0;
      round_over   = 1'b0;
      unique case (st_q)
         StIdle: begin
            if (play) begin
               st_d      = StReq;
               hits_d    = '0;
               misses_d  = '0;
               spawned_d = '0;
            end
         end
         StReq: begin
            pos_req = 1'b1;
            st_d    = StLoad;
         end
         StLoad: begin
            x_d       = clamp_pos(hor_data, 10'd0, X_MAX);
            y_d       = clamp_pos(ver_data, Y_MIN, Y_MAX);
            spawned_d = (spawned_q == 4'hF) ? spawned_q : spawned_q + 1'b1;
            life_load = 1'b1;
            st_d      = StActive;
         end
         StActive: begin
            duck_visible = 1'b1;
            // A hit landing on the final cycle still counts as a hit.
            if (clicked_duck) begin
               hits_d   = (hits_q == 8'hFF) ? hits_q : hits_q + 1'b1;
               gap_load = 1'b1;
               st_d     = StGap;
            end else if (life_zero) begin
               misses_d = (misses_q == 4'hF) ? misses_q : misses_q + 1'b1;
               gap_load = 1'b1;
               st_d     = StGap;
            end
         end
         StGap: begin
            if (gap_zero) begin
               st_d = ((spawned_q == DUCKS_LIM) || (misses_q >= MISS_LIM)) ? StDone : StReq;
            end
         end
         StDone: begin
            round_over = 1'b1;
            if (!play) st_d = StIdle;
         end
         default: st_d = StIdle;
      endcase

      // Leaving PLAY mid-round abandons the duck but keeps the score.
      if (!play && (st_q != StIdle) && (st_q != StDone)) begin
         st_d      = StIdle;
         hits_d    = hits_q;
         misses_d  = misses_q;
         spawned_d = spawned_q;
         x_d       = x_q;
         y_d       = y_q;
         life_load = 1'b0;
         gap_load  = 1'b0;
         tmr_clear = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= StIdle;
         hits_q    <= '0;
         misses_q  <= '0;
         spawned_q <= '0;
         x_q       <= X_RESET;
         y_q       <= Y_RESET;
      end else begin
         st_q      <= st_d;
         hits_q    <= hits_d;
         misses_q  <= misses_d;
         spawned_q <= spawned_d;
         x_q       <= x_d;
         y_q       <= y_d;
      end
   end

   duck_timer #(.WIDTH(LIFE_W)) u_life_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (tmr_clear),
      .load     (life_load),
      .load_val (LIFE_LOAD),
      .en       (st_q == StActive),
      .zero     (life_zero)
   );

   duck_timer #(.WIDTH(GAP_W)) u_gap_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (tmr_clear),
      .load     (gap_load),
      .load_val (GAP_LOAD),
      .en       (st_q == StGap),
      .zero     (gap_zero)
   );

   assign duck_x  = x_q;
   assign duck_y  = y_q;
   assign hits    = hits_q;
   assign misses  = misses_q;
   assign spawned = spawned_q;

endmodule

// File: doc/duck_spawn_ctrl.md
DUCK_SPAWN_CTRL -- requirements
Module: duck_spawn_ctrl

Interface
REQ-001 SHALL have parameter LIFETIME_CYC, default 65_000_000, meaning the cycles a duck stays catchable (1 s at 65 MHz).
REQ-002 SHALL have parameter GAP_CYC, default 32_500_000, meaning the idle cycles between a duck ending and the next spawn request.
REQ-003 SHALL have parameter DUCKS_PER_ROUND, default 10, meaning the number of spawns per round.
REQ-004 SHALL have parameter MAX_MISSES, default 3, meaning the number of escapes that ends the round early.
REQ-005 SHALL have ports clk (in, 1): the single clock; rst (in, 1): reset, synchronous and active-high.
REQ-006 SHALL have ports state (in, 2): game state; clicked_duck (in, 1): single-cycle hit pulse.
REQ-007 SHALL have ports hor_data (in, 10) and ver_data (in, 10): raw position from the random number generator.
REQ-008 SHALL have port pos_req (out, 1): single-cycle pulse asking the generator to advance.
REQ-009 SHALL have ports duck_x (out, 10), duck_y (out, 10): latched duck position; duck_visible (out, 1).
REQ-010 SHALL have ports hits (out, 8), misses (out, 4), spawned (out, 4): round counters.
REQ-011 SHALL have port round_over (out, 1): level signal, high in DONE.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, LOAD, ACTIVE, GAP, DONE.
REQ-013 IDLE -> REQ SHALL occur when state==PLAY; on that transition hits, misses and spawned SHALL clear to 0.
REQ-014 REQ SHALL assert pos_req for exactly one cycle, then go to LOAD.
REQ-015 LOAD SHALL capture hor_data/ver_data one cycle after pos_req, so the generator's registered update is sampled; it SHALL then go to ACTIVE and increment spawned.
REQ-016 On capture, duck_x SHALL be min(hor_data, 896), and duck_y SHALL be clamped to the range 96..640; this keeps a 64x64 duck inside 960x704.
REQ-017 ACTIVE SHALL assert duck_visible and load the lifetime counter with LIFETIME_CYC-1, decrementing it once per cycle.
REQ-018 In ACTIVE, clicked_duck=1 SHALL increment hits (saturating at 255) and go to GAP.
REQ-019 In ACTIVE, counter==0 without a hit SHALL increment misses (saturating at 15) and go to GAP.
REQ-020 If clicked_duck and expiry coincide, the hit SHALL win: hits is incremented and misses is unchanged.
REQ-021 clicked_duck SHALL be ignored in all states other than ACTIVE.
REQ-022 GAP SHALL last GAP_CYC cycles with duck_visible=0; it SHALL then go to DONE if spawned==DUCKS_PER_ROUND or misses>=MAX_MISSES, else to REQ.
REQ-023 DONE SHALL hold round_over=1 and keep the counters frozen; it SHALL return to IDLE when state!=PLAY.
REQ-024 From any state other than IDLE or DONE, state!=PLAY SHALL force IDLE next cycle, drop duck_visible, and clear the timers; the counters SHALL be preserved.
REQ-025 duck_x and duck_y SHALL hold their last value outside LOAD.

Reset
REQ-026 With rst=1 at a clk edge, the state SHALL become IDLE.
REQ-027 The same reset SHALL set pos_req=0, duck_visible=0, round_over=0, duck_x=450, duck_y=96, and hits=misses=spawned=0.
REQ-028 Reset SHALL clear both timers, SHALL take priority over every other input, and SHALL behave identically when asserted mid-ACTIVE.

Structure
REQ-029 The game-state encodings (START=2'b00, PLAY=2'b01, END=2'b10) and the screen/duck geometry constants (960, 704, 64, 96) SHALL live in the shared game definitions package.
REQ-030 The FSM state encoding SHALL be local to this module.
REQ-031 One sub-module, duck_timer, SHALL provide a loadable down-counter with a zero flag, instantiated twice: once for lifetime and once for gap.

Verification
REQ-032 Bench parameters SHALL be LIFETIME_CYC=20, GAP_CYC=4, DUCKS_PER_ROUND=3, MAX_MISSES=2.
REQ-033 Scenario 1: state=PLAY, hor_data=500, ver_data=200, no clicks. Required: pos_req pulses once; duck_x=500 and duck_y=200 two cycles later; duck_visible high for 20 cycles; misses=1.
REQ-034 Scenario 2: hor_data=1000, ver_data=20. Required: duck_x=896, duck_y=96; a later ver_data=700 gives duck_y=640.
REQ-035 Scenario 3: clicked_duck on the 5th ACTIVE cycle of each duck. Required: hits=3, misses=0, spawned=3, round_over=1 after the third GAP.
REQ-036 Scenario 4: no clicks. Required: DONE after the second escape, with misses=2 and spawned=2.
REQ-037 Scenario 5: clicked_duck in the cycle the lifetime counter reaches 0. Required: hits +1, misses unchanged.
REQ-038 Scenario 6: state->START mid-ACTIVE. Required: IDLE next cycle, duck_visible=0, counters held; returning to PLAY clears counters; rst mid-GAP gives all reset values.
